// File: rtl/onewire_pkg.sv
// -----------------------------------------------------------------------------
// onewire_pkg
// Shared definitions for the 1-Wire master write-slot generator:
//   - state_t          : slot FSM states (IDLE, LOW, RECOVER)
//   - T_*_DEFAULT      : default slot timing in clock cycles
//   - max3()           : helper used to size the slot duration counter
// -----------------------------------------------------------------------------
package onewire_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOW     = 2'd1,
      RECOVER = 2'd2
   } state_t;

   localparam int T_LOW1_DEFAULT = 6;   // bus-low cycles, write-1 slot
   localparam int T_LOW0_DEFAULT = 60;  // bus-low cycles, write-0 slot
   localparam int T_REC_DEFAULT  = 1;   // released cycles after every slot

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/onewire_slot_timer.sv
// -----------------------------------------------------------------------------
// onewire_slot_timer
// Loadable down-counter that times one phase of a 1-Wire slot. A phase loaded
// with value N lasts N+1 cycles; done is high in the last cycle of the phase.
// The counter stops at zero and never wraps.
// Ports:
//   clk        : clock, posedge
//   rst        : synchronous active-high reset (count cleared to 0)
//   load       : load load_value on this edge (takes priority over counting)
//   load_value : remaining-cycle count to load (phase length minus one)
//   done       : count has reached its terminal value (0)
// -----------------------------------------------------------------------------
module onewire_slot_timer #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         done
);

   logic [W-1:0] count;

   // NOTE: sequential state is assigned with non-blocking (<=) so every flop
   // samples the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/master_tx.sv
// -----------------------------------------------------------------------------
// master_tx
// 1-Wire master write-slot generator. When ready is seen in IDLE, bit_to_send
// is latched and the bus is pulled low for T_LOW1 (bit 1) or T_LOW0 (bit 0)
// cycles, then released for T_REC recovery cycles. Inputs are ignored while a
// slot is in progress. With ready held high, slots run back-to-back with no
// extra idle cycle: the edge that ends RECOVER also acts as the IDLE decision.
// Ports:
//   clk         : clock, posedge
//   rst         : synchronous active-high reset, aborts any slot in progress
//   bit_to_send : data bit for the next slot (1 = write-1, 0 = write-0)
//   ready       : level-sensitive request to start a slot
//   bus_out     : registered 1-Wire drive (0 = pull low, 1 = released)
// -----------------------------------------------------------------------------
module master_tx
   import onewire_pkg::*;
#(
   parameter int T_LOW1 = T_LOW1_DEFAULT,
   parameter int T_LOW0 = T_LOW0_DEFAULT,
   parameter int T_REC  = T_REC_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic bit_to_send,
   input  logic ready,
   output logic bus_out
);

   localparam int CW = $clog2(max3(T_LOW0, T_LOW1, T_REC)) + 1;

   // Phase length N is loaded as N-1 because the entry cycle counts.
   localparam logic [CW-1:0] LOAD_LOW1 = CW'(T_LOW1 - 1);
   localparam logic [CW-1:0] LOAD_LOW0 = CW'(T_LOW0 - 1);
   localparam logic [CW-1:0] LOAD_REC  = CW'(T_REC - 1);

   state_t        state;
   state_t        state_next;
   logic          slot_bit;
   logic          latch_bit;
   logic          load;
   logic [CW-1:0] load_value;
   logic          done;

   onewire_slot_timer #(
      .W (CW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_value (load_value),
      .done       (done)
   );

   // NOTE: every signal driven here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      load_value = '0;
      latch_bit  = 1'b0;

      case (state)
         IDLE: begin
            if (ready) begin
               state_next = LOW;
               load       = 1'b1;
               load_value = bit_to_send ? LOAD_LOW1 : LOAD_LOW0;
               latch_bit  = 1'b1;
            end
         end
         LOW: begin
            if (done) begin
               state_next = RECOVER;
               load       = 1'b1;
               load_value = LOAD_REC;
            end
         end
         RECOVER: begin
            // Final recovery edge doubles as the IDLE decision so that a held
            // ready yields a slot period of exactly T_LOWx + T_REC.
            if (done) begin
               if (ready) begin
                  state_next = LOW;
                  load       = 1'b1;
                  load_value = bit_to_send ? LOAD_LOW1 : LOAD_LOW0;
                  latch_bit  = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // NOTE: only control flops are reset here; the timer clears its own count,
   // and reset priority over everything else aborts a slot mid-phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         slot_bit <= 1'b0;
         bus_out  <= 1'b1;
      end else begin
         state   <= state_next;
         bus_out <= (state_next != LOW);
         if (latch_bit) begin
            slot_bit <= bit_to_send;
         end
      end
   end

   // The latched bit only selects the phase length at load time; it is kept
   // as the slot's record of what is being written.
   logic unused_slot_bit;
   assign unused_slot_bit = slot_bit;

endmodule

// File: tb/tb_master_tx.sv
// -----------------------------------------------------------------------------
// tb_master_tx
// Randomised, scoreboard-checked bench for master_tx. A behavioural model
// expands each accepted request into a list of expected bus levels (T_LOW
// zeros followed by T_REC ones); the expected level for each cycle is queued
// at the posedge and a separate monitor compares it with bus_out at negedge.
// -----------------------------------------------------------------------------
module tb_master_tx;

   localparam int T_LOW1 = 6;
   localparam int T_LOW0 = 60;
   localparam int T_REC  = 1;

   logic clk;
   logic rst;
   logic bit_to_send;
   logic ready;
   logic bus_out;

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;

   logic pending_slot[$];   // remaining bus levels of the slot in progress
   logic sb_q[$];           // expected bus_out per cycle

   master_tx #(
      .T_LOW1 (T_LOW1),
      .T_LOW0 (T_LOW0),
      .T_REC  (T_REC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bit_to_send (bit_to_send),
      .ready       (ready),
      .bus_out     (bus_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic actual, input logic expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, actual, expected);
      end
   endtask

   // Reference model: a slot is just a list of levels; a new request is only
   // accepted when the previous slot's list has been fully consumed.
   always @(posedge clk) begin
      logic lvl;
      cycle++;
      if (rst) begin
         pending_slot.delete();
         lvl = 1'b1;
      end else begin
         if (pending_slot.size() == 0 && ready) begin
            for (int i = 0; i < (bit_to_send ? T_LOW1 : T_LOW0); i++)
               pending_slot.push_back(1'b0);
            for (int i = 0; i < T_REC; i++)
               pending_slot.push_back(1'b1);
         end
         if (pending_slot.size() > 0) lvl = pending_slot.pop_front();
         else                         lvl = 1'b1;
      end
      sb_q.push_back(lvl);
   end

   // Monitor: compare away from the active edge.
   always @(negedge clk) begin
      logic exp_lvl;
      if (sb_q.size() > 0) begin
         exp_lvl = sb_q.pop_front();
         check($sformatf("bus_out@cycle%0d", cycle), bus_out, exp_lvl);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-sample request, then release ready.
   task automatic pulse_req(input logic b);
      ready       = 1'b1;
      bit_to_send = b;
      step(1);
      ready       = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      ready       = 1'b0;
      bit_to_send = 1'b0;
      step(3);
      rst = 1'b0;

      // Idle with ready low: bus stays released.
      bit_to_send = 1'b1;
      step(20);

      // Single write-1 slot.
      pulse_req(1'b1);
      step(15);

      // Single write-0 slot.
      pulse_req(1'b0);
      step(70);

      // Back-to-back: write-1 then bit switched to 0 during recovery.
      ready       = 1'b1;
      bit_to_send = 1'b1;
      step(6);                 // start edge plus five more low cycles
      step(1);                 // now in the recovery cycle
      bit_to_send = 1'b0;
      step(1);                 // next slot starts with bit 0
      ready = 1'b0;
      step(70);

      // Inputs churning during a write-0 slot must not change its length.
      pulse_req(1'b0);
      for (int i = 0; i < 65; i++) begin
         bit_to_send = 1'($urandom);
         ready       = (i < 55) ? 1'($urandom) : 1'b0;
         step(1);
      end
      ready = 1'b0;
      step(10);

      // Reset at low cycle 30 of a write-0 slot, then a fresh slot.
      pulse_req(1'b0);
      step(29);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(3);
      pulse_req(1'b0);
      step(70);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         ready       = ($urandom_range(0, 3) != 0);
         bit_to_send = ($urandom_range(0, 2) != 0);
         rst         = ($urandom_range(0, 199) == 0);
         step(1);
      end
      rst   = 1'b0;
      ready = 1'b0;
      step(70);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/master_tx.md
MASTER_TX -- requirements
Module: master_tx

Interface
REQ-001 Parameter T_LOW1, default 6: bus-low cycles for a write-1 slot.
REQ-002 Parameter T_LOW0, default 60: bus-low cycles for a write-0 slot.
REQ-003 Parameter T_REC, default 1: released (high) recovery cycles after every slot.
REQ-004 Port clk, input, 1: single clock; all logic on posedge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port bit_to_send, input, 1: data bit for the next slot; 1 = write-1, 0 = write-0.
REQ-007 Port ready, input, 1: request to start a slot; level-sensitive.
REQ-008 Port bus_out, output, 1: 1-Wire drive; 0 = pull low, 1 = released/idle.
REQ-009 No other ports SHALL exist.

Function
REQ-010 bus_out SHALL be a registered output, driven only from a flop.
REQ-011 The FSM SHALL have exactly three states: IDLE, LOW, RECOVER.
REQ-012 In IDLE, bus_out SHALL be 1.
REQ-013 In IDLE with ready=0 on a posedge, the FSM SHALL stay in IDLE.
REQ-014 In IDLE with ready=1 on a posedge:
- bit_to_send SHALL be latched into a slot-bit register.
- The FSM SHALL enter LOW.
- bus_out SHALL be 0 from that same edge (1-cycle latency from the ready sample).
REQ-015 In LOW, bus_out SHALL stay 0 for exactly T_LOW1 cycles (latched bit=1) or T_LOW0 cycles (latched bit=0), counting the entry cycle.
REQ-016 After the low phase, the FSM SHALL enter RECOVER with bus_out=1 for exactly T_REC cycles, then return to IDLE.
REQ-017 ready and bit_to_send SHALL be ignored in LOW and RECOVER; input changes mid-slot SHALL NOT alter the slot length.
REQ-018 With ready held high, slots SHALL run back-to-back: the next slot goes low on the first posedge after RECOVER ends.
- Slot period = T_LOW1+T_REC (7) for bit 1.
- Slot period = T_LOW0+T_REC (61) for bit 0.
REQ-019 Duration counter:
- Width SHALL be clog2(max(T_LOW0,T_LOW1,T_REC))+1 bits.
- SHALL load at state entry and count down to terminal value.
- SHALL NOT wrap.
REQ-020 Unknown/illegal state encodings SHALL return to IDLE with bus_out=1.

Reset
REQ-021 On a posedge with rst=1: state=IDLE, bus_out=1, counter=0, slot-bit=0.
REQ-022 Reset SHALL take priority over all other conditions and SHALL abort a slot in progress, including mid-LOW; bus_out SHALL be 1 by the following posedge.
REQ-023 In the first cycle after rst deasserts, the FSM SHALL be in IDLE and SHALL sample ready normally.

Structure
REQ-024 Package onewire_pkg SHALL hold:
- the state enum (IDLE, LOW, RECOVER);
- default timing constants (6, 60, 1).
REQ-025 One sub-module is natural: onewire_slot_timer (loadable down-counter with done flag), instantiated once. The FSM and output flop SHALL reside in master_tx.

Verification
REQ-026 Hold ready=0 with bit_to_send=1 after reset: bus_out=1 on every cycle.
REQ-027 Assert ready=1 with bit_to_send=1 for one sample, then ready=0: bus_out=0 for exactly 6 cycles, then 1 cycle high, then idle high.
REQ-028 Assert ready=1 with bit_to_send=0: bus_out=0 for exactly 60 cycles, then high.
REQ-029 Hold ready=1, bit_to_send=1 for 6 low cycles, then switch bit_to_send=0 during recovery: 6 low, 1 high, 60 low (no glitch), 1 high.
REQ-030 Toggle bit_to_send during a write-0 slot: low length stays 60.
REQ-031 Assert rst at low cycle 30 of a write-0 slot: bus_out=1 on the next cycle; a new ready starts a fresh 60-cycle slot.
